// File: rtl/myproject_mac_sched.sv
// Dense-layer MAC sequencer: one shared signed multiplier,
// N_OUT dot products of N_IN terms, start/done handshake.
module myproject_mac_sched #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int DATA_W = 12,
  parameter int WGT_W  = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic [N_IN*DATA_W-1:0]       data_i,
  input  logic [N_IN*N_OUT*WGT_W-1:0]  wgt_i,
  output logic [N_OUT*ACC_W-1:0]       res_o,
  output logic [DATA_W-1:0]            mul_din0,
  output logic [WGT_W-1:0]             mul_din1,
  input  logic [PROD_W-1:0]            mul_dout
);

  localparam int NK = N_IN * N_OUT;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    LAST,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N_IN*DATA_W-1:0]  data_r;
  logic [NK*WGT_W-1:0]     wgt_r;
  logic [IW-1:0]           i;
  logic [JW-1:0]           j;
  logic [KW-1:0]           k;
  logic [IW-1:0]           ni;
  logic [JW-1:0]           nj;
  logic [KW-1:0]           nk;
  logic                    last_i;
  logic                    last_pair;
  logic [PROD_W-1:0]       prod_r;
  logic [JW-1:0]           prod_j;
  logic                    prod_v;
  logic [ACC_W-1:0]        prod_x;
  logic [ACC_W-1:0]        acc    [N_OUT];
  logic [ACC_W-1:0]        acc_nx [N_OUT];

  assign last_i    = (i == IW'(N_IN - 1));
  assign last_pair = last_i && (j == JW'(N_OUT - 1));

  // k walks the weight array linearly, so it always equals j*N_IN+i
  always_comb begin
    ni = last_i ? '0 : i + 1'b1;
    nj = last_pair ? '0 : (last_i ? j + 1'b1 : j);
    nk = last_pair ? '0 : k + 1'b1;
  end

  assign prod_x = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};

  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      acc_nx[n] = acc[n];
      if (prod_v && (prod_j == JW'(n)))
        acc_nx[n] = acc[n] + prod_x;
    end
  end

  always_comb begin
    state_nx = state;
    ap_ready = 1'b0;
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    unique case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready = 1'b1;
          state_nx = MUL;
        end
      end
      MUL: begin
        if (last_pair)
          state_nx = LAST;
      end
      LAST: state_nx = DONE;
      DONE: begin
        ap_done  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int n = 0; n < N_OUT; n++)
        acc[n] <= '0;
      data_r   <= '0;
      wgt_r    <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      prod_r   <= '0;
      prod_j   <= '0;
      prod_v   <= 1'b0;
      res_o    <= '0;
      mul_din0 <= '0;
      mul_din1 <= '0;
    end else begin
      for (int n = 0; n < N_OUT; n++)
        acc[n] <= acc_nx[n];
      prod_v <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ap_start) begin
            for (int n = 0; n < N_OUT; n++)
              acc[n] <= '0;
            data_r   <= data_i;
            wgt_r    <= wgt_i;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            mul_din0 <= data_i[DATA_W-1:0];
            mul_din1 <= wgt_i[WGT_W-1:0];
          end
        end
        MUL: begin
          prod_r   <= mul_dout;
          prod_j   <= j;
          prod_v   <= 1'b1;
          i        <= ni;
          j        <= nj;
          k        <= nk;
          mul_din0 <= data_r[int'(ni)*DATA_W +: DATA_W];
          mul_din1 <= wgt_r[int'(nk)*WGT_W +: WGT_W];
        end
        LAST: begin
          for (int n = 0; n < N_OUT; n++)
            res_o[n*ACC_W +: ACC_W] <= acc_nx[n];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_mac_sched.sv
// Bench for myproject_mac_sched: directed jobs, scoreboard of
// expected results, behavioural truncating multiplier.
module tb_myproject_mac_sched;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int DATA_W = 12;
  localparam int WGT_W  = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int NK     = N_IN * N_OUT;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst_n;
  logic                      ap_start;
  logic                      ap_ready;
  logic                      ap_idle;
  logic                      ap_done;
  logic [N_IN*DATA_W-1:0]    data_i;
  logic [NK*WGT_W-1:0]       wgt_i;
  logic [N_OUT*ACC_W-1:0]    res_o;
  logic [DATA_W-1:0]         mul_din0;
  logic [WGT_W-1:0]          mul_din1;
  logic [PROD_W-1:0]         mul_dout;
  logic signed [19:0]        full;

  assign full     = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = full[PROD_W-1:0];

  always #5 ap_clk = ~ap_clk;

  myproject_mac_sched #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .DATA_W(DATA_W),
    .WGT_W (WGT_W),
    .PROD_W(PROD_W),
    .ACC_W (ACC_W)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle (ap_idle),
    .ap_done (ap_done),
    .data_i  (data_i),
    .wgt_i   (wgt_i),
    .res_o   (res_o),
    .mul_din0(mul_din0),
    .mul_din1(mul_din1),
    .mul_dout(mul_dout)
  );

  typedef struct {
    logic [N_OUT*ACC_W-1:0] res;
    int                     done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   nchecks = 0;
  int   nerr    = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_OUT*ACC_W-1:0] model(
    input logic [N_IN*DATA_W-1:0] d,
    input logic [NK*WGT_W-1:0]    w);
    logic [N_OUT*ACC_W-1:0] r;
    logic [ACC_W-1:0]       a;
    logic [15:0]            t;
    int                     p;
    r = '0;
    for (int jj = 0; jj < N_OUT; jj++) begin
      a = '0;
      for (int ii = 0; ii < N_IN; ii++) begin
        p = int'($signed(d[ii*DATA_W +: DATA_W]))
          * int'($signed(w[(jj*N_IN+ii)*WGT_W +: WGT_W]));
        t = p[15:0];
        a = a + {{(ACC_W-16){t[15]}}, t};
      end
      r[jj*ACC_W +: ACC_W] = a;
    end
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (ap_done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(ap_done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cyc", 64'(cyc), 64'(e.done_cyc));
        chk("res", 64'(res_o), 64'(e.res));
      end
    end
  endtask

  task automatic accept_job();
    exp_t e;
    ap_start = 1'b1;
    #1;
    chk("ready", 64'(ap_ready), 64'd1);
    e.res      = model(data_i, wgt_i);
    e.done_cyc = cyc + NK + 2;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && sb.size() > 0; n++)
      tick();
    chk("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic set_all(input int d, input int w);
    for (int n = 0; n < N_IN; n++)
      data_i[n*DATA_W +: DATA_W] = DATA_W'(d);
    for (int n = 0; n < NK; n++)
      wgt_i[n*WGT_W +: WGT_W] = WGT_W'(w);
  endtask

  task automatic set_rand();
    for (int n = 0; n < N_IN; n++)
      data_i[n*DATA_W +: DATA_W] = DATA_W'($urandom);
    for (int n = 0; n < NK; n++)
      wgt_i[n*WGT_W +: WGT_W] = WGT_W'($urandom);
  endtask

  int                     c0;
  int                     ndone;
  logic [N_OUT*ACC_W-1:0] prev;

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    data_i   = '0;
    wgt_i    = '0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    #1;
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_ready", 64'(ap_ready), 64'd0);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_res", 64'(res_o), 64'd0);
    chk("rst_din0", 64'(mul_din0), 64'd0);
    chk("rst_din1", 64'(mul_din1), 64'd0);
    tick();

    // basic job
    for (int n = 0; n < N_IN; n++) begin
      data_i[n*DATA_W +: DATA_W] = DATA_W'(n + 1);
      wgt_i[n*WGT_W +: WGT_W]    = WGT_W'(1);
      wgt_i[(N_IN+n)*WGT_W +: WGT_W] = WGT_W'(-(n + 1));
    end
    c0 = cyc;
    accept_job();
    tick();
    ap_start = 1'b0;
    set_rand();
    wait_done();
    chk("basic_res0", 64'(res_o[ACC_W-1:0]), 64'(20'd10));
    chk("basic_res1", 64'(res_o[2*ACC_W-1:ACC_W]), 64'(20'hFFFE2));
    chk("basic_cyc", 64'(cyc), 64'(c0 + 10));
    tick();
    chk("idle_after", 64'(ap_idle), 64'd1);

    // truncation
    set_all(2047, 127);
    accept_job();
    tick();
    ap_start = 1'b0;
    wait_done();
    chk("trunc_res0", 64'(res_o[ACC_W-1:0]), 64'(20'hFDE04));
    chk("trunc_res1", 64'(res_o[2*ACC_W-1:ACC_W]), 64'(20'hFDE04));
    tick();

    // sign extremes
    set_all(-2048, -128);
    accept_job();
    tick();
    ap_start = 1'b0;
    wait_done();
    chk("ext_res", 64'(res_o), 64'd0);
    tick();

    // back-to-back with ap_start held high
    set_rand();
    c0 = cyc;
    accept_job();
    tick();
    set_rand();
    for (int n = 0; n < 20 && !ap_ready; n++)
      tick();
    chk("b2b_accept", 64'(ap_ready), 64'd1);
    chk("b2b_accept_cyc", 64'(cyc), 64'(c0 + 11));
    accept_job();
    tick();
    ap_start = 1'b0;
    set_rand();
    wait_done();
    chk("b2b_done_cyc", 64'(cyc), 64'(c0 + 21));
    tick();

    // reset in the middle of a job
    set_rand();
    c0 = cyc;
    accept_job();
    tick();
    ap_start = 1'b0;
    while (cyc < c0 + 5)
      tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    sb.delete();
    chk("abort_idle", 64'(ap_idle), 64'd1);
    chk("abort_res", 64'(res_o), 64'd0);
    chk("abort_din0", 64'(mul_din0), 64'd0);
    chk("abort_din1", 64'(mul_din1), 64'd0);
    ndone = 0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (ap_done)
        ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    set_rand();
    accept_job();
    tick();
    ap_start = 1'b0;
    wait_done();
    tick();

    // idle stability
    prev = res_o;
    for (int n = 0; n < 20; n++) begin
      set_rand();
      tick();
      chk("stab_idle", 64'(ap_idle), 64'd1);
      chk("stab_done", 64'(ap_done), 64'd0);
      chk("stab_ready", 64'(ap_ready), 64'd0);
      chk("stab_res", 64'(res_o), 64'(prev));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
